// File: rtl/telemetry_framer.sv
// Telemetry framer: atomically snapshots NUM_CH sensor words and streams the masked ones
// as a SYNC / seq / count / data / checksum packet over a serial_tx-style byte handshake.
module telemetry_framer #(
    parameter int          NUM_CH    = 16,
    parameter int          CH_W      = 16,
    parameter int          PERIOD    = 500000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  CMD_SNAP  = 8'h53
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     mode,
    input  logic [7:0]               rx_data,
    input  logic                     new_rx_data,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_block,
    output logic                     frame_active,
    output logic [7:0]               seq,
    output logic [15:0]              frame_count,
    output logic                     overrun
);

    localparam int NB = CH_W / 8;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, SNAP, SEND, WAIT} state_t;
    typedef enum logic [2:0] {PH_SYNC, PH_SEQ, PH_CNT, PH_DATA, PH_CSUM} phase_t;

    state_t                  state;
    phase_t                  phase;
    logic [PW-1:0]           period_cnt;
    logic [NUM_CH*CH_W-1:0]  shadow_data;
    logic [NUM_CH-1:0]       shadow_mask;
    logic [IW-1:0]           ch_idx;
    logic [BW-1:0]           byte_idx;
    logic [7:0]              csum;
    logic                    wait_first;

    logic                    trigger;
    logic                    frame_done;
    logic [7:0]              n_en;
    logic                    first_found;
    logic [IW-1:0]           first_idx;
    logic                    next_found;
    logic [IW-1:0]           next_idx;
    logic [CH_W-1:0]         cur_word;
    logic [7:0]              data_byte;
    logic [7:0]              cur_byte;

    assign trigger    = mode ? (new_rx_data && (rx_data == CMD_SNAP))
                             : (period_cnt == PW'(PERIOD - 1));
    assign frame_done = (state == WAIT) && !wait_first && !tx_busy && (phase == PH_CSUM);

    // Descending scan so the lowest enabled index wins; also finds the next enabled channel above ch_idx.
    always_comb begin
        n_en        = '0;
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        cur_word    = '0;
        data_byte   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (shadow_mask[i]) begin
                n_en        = n_en + 8'd1;
                first_found = 1'b1;
                first_idx   = IW'(i);
                if (i > int'(ch_idx)) begin
                    next_found = 1'b1;
                    next_idx   = IW'(i);
                end
            end
            if (ch_idx == IW'(i))
                cur_word = shadow_data[i*CH_W +: CH_W];
        end
        for (int b = 0; b < NB; b++) begin
            if (byte_idx == BW'(b))
                data_byte = cur_word[(NB-1-b)*8 +: 8];
        end
        case (phase)
            PH_SYNC: cur_byte = SYNC_BYTE;
            PH_SEQ:  cur_byte = seq;
            PH_CNT:  cur_byte = n_en;
            PH_DATA: cur_byte = data_byte;
            default: cur_byte = csum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= PH_SYNC;
            period_cnt   <= '0;
            shadow_data  <= '0;
            shadow_mask  <= '0;
            ch_idx       <= '0;
            byte_idx     <= '0;
            csum         <= '0;
            wait_first   <= 1'b0;
            tx_data      <= '0;
            new_tx_data  <= 1'b0;
            frame_active <= 1'b0;
            seq          <= '0;
            frame_count  <= '0;
            overrun      <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            overrun     <= trigger && (state != IDLE) && !frame_done;
            if (mode || (period_cnt == PW'(PERIOD - 1)))
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state        <= SNAP;
                        frame_active <= 1'b1;
                    end
                end
                SNAP: begin
                    shadow_data <= ch_data;
                    shadow_mask <= ch_mask;
                    phase       <= PH_SYNC;
                    ch_idx      <= '0;
                    byte_idx    <= '0;
                    csum        <= '0;
                    state       <= SEND;
                end
                SEND: begin
                    if (!tx_busy && !tx_block) begin
                        tx_data     <= cur_byte;
                        new_tx_data <= 1'b1;
                        if ((phase != PH_SYNC) && (phase != PH_CSUM))
                            csum <= csum + cur_byte;
                        wait_first  <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // The transmitter may not raise busy until a cycle after our strobe.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (!tx_busy) begin
                        state <= SEND;
                        case (phase)
                            PH_SYNC: phase <= PH_SEQ;
                            PH_SEQ:  phase <= PH_CNT;
                            PH_CNT: begin
                                if (first_found) begin
                                    phase    <= PH_DATA;
                                    ch_idx   <= first_idx;
                                    byte_idx <= '0;
                                end else begin
                                    phase <= PH_CSUM;
                                end
                            end
                            PH_DATA: begin
                                if (byte_idx != BW'(NB - 1)) begin
                                    byte_idx <= byte_idx + 1'b1;
                                end else if (next_found) begin
                                    ch_idx   <= next_idx;
                                    byte_idx <= '0;
                                end else begin
                                    phase <= PH_CSUM;
                                end
                            end
                            default: begin
                                frame_active <= trigger;
                                seq          <= seq + 8'd1;
                                frame_count  <= frame_count + 16'd1;
                                state        <= trigger ? SNAP : IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: scoreboarded byte stream, table of request-mode frames,
// plus flow-control, periodic, overrun, snapshot and mid-frame reset sequences.
module tb_telemetry_framer;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 16;
    localparam int PERIOD = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ch_data;
    logic [3:0]  ch_mask;
    logic        mode;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic        tx_block;
    logic        frame_active;
    logic [7:0]  seq;
    logic [15:0] frame_count;
    logic        overrun;

    telemetry_framer #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD(PERIOD),
        .SYNC_BYTE(8'hA5), .CMD_SNAP(8'h53)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_mask(ch_mask), .mode(mode),
        .rx_data(rx_data), .new_rx_data(new_rx_data), .tx_data(tx_data),
        .new_tx_data(new_tx_data), .tx_busy(tx_busy), .tx_block(tx_block),
        .frame_active(frame_active), .seq(seq), .frame_count(frame_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] data;
        logic [7:0]  rx;
        bit          frame;
        logic [7:0]  exp_csum;
        int          busy;
    } vec_t;

    vec_t        vecs[6];
    logic [7:0]  exp_q[$];
    int          rise_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          overruns_seen = 0;
    int          busy_len = 0;
    int          busy_cnt = 0;
    logic [7:0]  last_byte = 8'h00;
    logic [7:0]  m_seq = 8'h00;
    logic [15:0] m_count = 16'h0000;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Byte monitor plus a simple UART model that stays busy for busy_len cycles per byte.
    task automatic monitor_loop();
        logic       prev_fa;
        logic [7:0] e;
        prev_fa = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (new_tx_data) begin
                strobes++;
                last_byte = tx_data;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL tx_byte_unexpected actual=%0h required=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        failures++;
                        $display("[TB] FAIL tx_byte actual=%0h required=%0h", tx_data, e);
                    end
                end
            end
            if (overrun) overruns_seen++;
            if (frame_active && !prev_fa) rise_q.push_back(cyc);
            prev_fa = frame_active;
            if (!rst_n)           busy_cnt = 0;
            else if (new_tx_data) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt != 0);
        end
    endtask

    task automatic push_frame(input logic [7:0] s, input logic [3:0] m, input logic [63:0] d,
                              output int len);
        logic [7:0] n, cs, hi, lo;
        n = 8'h00;
        for (int i = 0; i < NUM_CH; i++) if (m[i]) n = n + 8'd1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back(n);
        cs = s + n;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                hi = d[i*16+8 +: 8];
                lo = d[i*16 +: 8];
                exp_q.push_back(hi);
                exp_q.push_back(lo);
                cs = cs + hi + lo;
            end
        end
        exp_q.push_back(cs);
        len = 4 + 2 * int'(n);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(frame_count == m_count && exp_q.size() == 0 && !frame_active) && n < 3000) begin
            tick();
            n++;
        end
        check(name, (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, output int len);
        len      = 0;
        ch_mask  = v.mask;
        ch_data  = v.data;
        busy_len = v.busy;
        if (v.frame) begin
            push_frame(m_seq, v.mask, v.data, len);
            m_seq   = m_seq + 8'd1;
            m_count = m_count + 16'd1;
        end
        send_rx(v.rx);
        if (v.frame) wait_done("frame_timeout");
        else repeat (60) tick();
    endtask

    task automatic checkOutput(input vec_t v, input int idx, input int len, input int s0);
        check($sformatf("v%0d_frame_count", idx), 32'(frame_count), 32'(m_count));
        check($sformatf("v%0d_seq", idx), 32'(seq), 32'(m_seq));
        check($sformatf("v%0d_frame_active", idx), 32'(frame_active), 32'd0);
        check($sformatf("v%0d_strobes", idx), 32'(strobes - s0), 32'(len));
        if (v.frame) check($sformatf("v%0d_csum", idx), 32'(last_byte), 32'(v.exp_csum));
    endtask

    initial begin
        int len, s0, ov0, mode_cyc, n;
        vecs[0] = '{4'b0101, {16'h6666, 16'hABCD, 16'h5555, 16'h1234}, 8'h53, 1'b1, 8'hC0, 1};
        vecs[1] = '{4'b0000, {16'h6666, 16'hABCD, 16'h5555, 16'h1234}, 8'h53, 1'b1, 8'h01, 0};
        vecs[2] = '{4'b0000, 64'h0, 8'h54, 1'b0, 8'h00, 0};
        vecs[3] = '{4'b1111, {16'h0607, 16'h0405, 16'h0203, 16'h0001}, 8'h53, 1'b1, 8'h22, 3};
        vecs[4] = '{4'b1000, {16'hFFFF, 48'h0}, 8'h53, 1'b1, 8'h02, 2};
        vecs[5] = '{4'b0010, {32'h0, 16'h8000, 16'h0}, 8'h53, 1'b1, 8'h85, 0};

        rst_n = 1'b0; ch_data = '0; ch_mask = '0; mode = 1'b1;
        rx_data = '0; new_rx_data = 1'b0; tx_busy = 1'b0; tx_block = 1'b0;
        fork
            monitor_loop();
        join_none
        repeat (3) tick();
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_new_tx_data", 32'(new_tx_data), 32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        check("rst_seq", 32'(seq), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            s0 = strobes;
            applyStimulus(vecs[i], len);
            checkOutput(vecs[i], i, len, s0);
        end

        // Flow control: hold tx_block for 100 cycles right after the first byte.
        ch_mask = 4'b0101; ch_data = vecs[0].data; busy_len = 1;
        push_frame(m_seq, 4'b0101, vecs[0].data, len);
        m_seq = m_seq + 8'd1; m_count = m_count + 16'd1;
        s0 = strobes;
        send_rx(8'h53);
        n = 0;
        while (strobes == s0 && n < 100) begin tick(); n++; end
        check("block_first_byte_seen", 32'(strobes - s0), 32'd1);
        tx_block = 1'b1;
        repeat (100) tick();
        check("block_no_strobes", 32'(strobes - s0), 32'd1);
        check("block_frame_active", 32'(frame_active), 32'd1);
        tx_block = 1'b0;
        wait_done("block_timeout");
        check("block_total_strobes", 32'(strobes - s0), 32'(len));
        check("block_seq", 32'(seq), 32'(m_seq));

        // Periodic mode, short frames: one frame every PERIOD cycles, rx ignored.
        ch_mask = 4'b0000; busy_len = 2;
        for (int k = 0; k < 3; k++) push_frame(m_seq + 8'(k), 4'b0000, 64'h0, len);
        m_seq = m_seq + 8'd3; m_count = m_count + 16'd3;
        rise_q.delete();
        ov0 = overruns_seen;
        mode = 1'b0;
        mode_cyc = cyc;
        repeat (40) tick();
        send_rx(8'h53);
        while (cyc < mode_cyc + 100) tick();
        mode = 1'b1;
        wait_done("periodic_timeout");
        check("periodic_frames", 32'(rise_q.size()), 32'd3);
        check("periodic_first", 32'((rise_q.size() > 0) ? rise_q[0] - mode_cyc : 0), 32'(PERIOD));
        check("periodic_gap1", 32'((rise_q.size() > 1) ? rise_q[1] - rise_q[0] : 0), 32'(PERIOD));
        check("periodic_gap2", 32'((rise_q.size() > 2) ? rise_q[2] - rise_q[1] : 0), 32'(PERIOD));
        check("periodic_no_overrun", 32'(overruns_seen - ov0), 32'd0);
        check("periodic_seq", 32'(seq), 32'(m_seq));

        // Periodic mode with frames longer than PERIOD: every other trigger is dropped.
        ch_mask = 4'b1111; ch_data = 64'h0102_0304_0506_0708;
        push_frame(m_seq, 4'b1111, ch_data, len);
        push_frame(m_seq + 8'd1, 4'b1111, ch_data, len);
        m_seq = m_seq + 8'd2; m_count = m_count + 16'd2;
        rise_q.delete();
        ov0 = overruns_seen;
        mode = 1'b0;
        mode_cyc = cyc;
        while (cyc < mode_cyc + 150) tick();
        mode = 1'b1;
        wait_done("overrun_timeout");
        check("overrun_pulses", 32'(overruns_seen - ov0), 32'd2);
        check("overrun_frames", 32'(rise_q.size()), 32'd2);
        check("overrun_frame_count", 32'(frame_count), 32'(m_count));

        // Snapshot isolation: channel data changes shortly after the trigger.
        ch_mask = 4'b0101; ch_data = vecs[0].data; busy_len = 1;
        push_frame(m_seq, 4'b0101, vecs[0].data, len);
        m_seq = m_seq + 8'd1; m_count = m_count + 16'd1;
        send_rx(8'h53);
        repeat (4) tick();
        ch_data = 64'hDEAD_BEEF_CAFE_F00D;
        ch_mask = 4'b1111;
        wait_done("snapshot_timeout");
        check("snapshot_seq", 32'(seq), 32'(m_seq));

        // Reset in the middle of the data bytes, then a fresh request frame.
        ch_mask = 4'b1111; ch_data = 64'h1111_2222_3333_4444;
        push_frame(m_seq, 4'b1111, ch_data, len);
        s0 = strobes;
        send_rx(8'h53);
        n = 0;
        while (strobes < s0 + 5 && n < 200) begin tick(); n++; end
        check("midreset_bytes_seen", 32'(strobes - s0), 32'd5);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("midreset_new_tx_data", 32'(new_tx_data), 32'd0);
        check("midreset_frame_active", 32'(frame_active), 32'd0);
        check("midreset_seq", 32'(seq), 32'd0);
        check("midreset_frame_count", 32'(frame_count), 32'd0);
        s0 = strobes;
        tick();
        rst_n = 1'b1;
        tick();
        check("midreset_no_strobes", 32'(strobes - s0), 32'd0);
        m_seq = 8'h00; m_count = 16'h0000;
        s0 = strobes;
        applyStimulus(vecs[0], len);
        checkOutput(vecs[0], 10, len, s0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
